game_setup_ctrl: RTL and testbench

//  Sequences game setup: runs the difficulty menu and computes board geometry for the chosen level.

---
 rtl/game_setup_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_setup_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_setup_ctrl.sv
// Difficulty menu and setup sequencer: picks a level, computes centred board geometry,
// pulses the settings latch once, then handshakes into PLAY until the game ends.
module game_setup_ctrl #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_confirm,
  input  logic        game_over,
  input  logic        setup_ack,
  output logic [1:0]  level,
  output logic        in_menu,
  output logic        latch_en,
  output logic        set_valid,
  output logic        playing,
  output logic [4:0]  button_num,
  output logic [6:0]  button_size,
  output logic [9:0]  board_size,
  output logic [10:0] board_xpos,
  output logic [10:0] board_ypos
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MENU     = 3'd1,
    COMPUTE  = 3'd2,
    LATCH    = 3'd3,
    WAIT_ACK = 3'd4,
    PLAY     = 3'd5
  } state_t;

  localparam logic [10:0] SCR_W = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H = 11'(SCREEN_H);

  // The largest board (hard level, 640 px) must fit on screen in both axes.
  if (SCREEN_W < 640 || SCREEN_H < 640 || SCREEN_W > 2047 || SCREEN_H > 2047) begin : g_screen_chk
    $error("game_setup_ctrl: screen too small for a 640 px board or too wide for 11 bits");
  end

  state_t      state, state_nxt;
  logic        up_p0, down_p0, confirm_p0;
  logic        in_menu_st;

  function automatic logic [4:0] lvl_num(input logic [1:0] lv);
    case (lv)
      2'd1:    lvl_num = 5'd12;
      2'd2:    lvl_num = 5'd16;
      default: lvl_num = 5'd8;
    endcase
  endfunction

  function automatic logic [6:0] lvl_size(input logic [1:0] lv);
    case (lv)
      2'd1:    lvl_size = 7'd48;
      2'd2:    lvl_size = 7'd40;
      default: lvl_size = 7'd64;
    endcase
  endfunction

  function automatic logic [9:0] lvl_board(input logic [1:0] lv);
    case (lv)
      2'd1:    lvl_board = 10'd576;
      2'd2:    lvl_board = 10'd640;
      default: lvl_board = 10'd512;
    endcase
  endfunction

  function automatic logic [10:0] centre(input logic [10:0] screen, input logic [9:0] board);
    logic [10:0] diff;
    diff   = screen - {1'b0, board};
    centre = diff >> 1;
  endfunction

  function automatic logic [1:0] lvl_next(input logic [1:0] lv, input logic up, input logic down);
    lvl_next = lv;
    if (up && !down)      lvl_next = (lv == 2'd2) ? 2'd0 : lv + 2'd1;
    else if (down && !up) lvl_next = (lv == 2'd0) ? 2'd2 : lv - 2'd1;
  endfunction

  assign in_menu_st = (state == MENU);

  // p0: menu buttons registered only while the menu is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_p0      <= 1'b0;
      down_p0    <= 1'b0;
      confirm_p0 <= 1'b0;
    end else begin
      up_p0      <= btn_up      & in_menu_st;
      down_p0    <= btn_down    & in_menu_st;
      confirm_p0 <= btn_confirm & in_menu_st;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = MENU;
      MENU:     state_nxt = confirm_p0 ? COMPUTE : MENU;
      COMPUTE:  state_nxt = LATCH;
      LATCH:    state_nxt = WAIT_ACK;
      WAIT_ACK: state_nxt = setup_ack ? PLAY : WAIT_ACK;
      PLAY:     state_nxt = game_over ? MENU : PLAY;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_menu   = (state == MENU);
    latch_en  = (state == LATCH);
    set_valid = (state == WAIT_ACK);
    playing   = (state == PLAY);
  end

  // Confirm takes priority: a confirm cycle never moves the level it is about to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            level <= 2'd0;
    else if (state == MENU && !confirm_p0) level <= lvl_next(level, up_p0, down_p0);
  end

  // p1: geometry captured in COMPUTE and held through LATCH, WAIT_ACK and PLAY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      button_num  <= '0;
      button_size <= '0;
      board_size  <= '0;
      board_xpos  <= '0;
      board_ypos  <= '0;
    end else if (state == COMPUTE) begin
      button_num  <= lvl_num(level);
      button_size <= lvl_size(level);
      board_size  <= lvl_board(level);
      board_xpos  <= centre(SCR_W, lvl_board(level));
      board_ypos  <= centre(SCR_H, lvl_board(level));
    end
  end

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Directed bench for game_setup_ctrl: level wrap table, per-level geometry table,
// handshake/ignored-input sequences and asynchronous reset in LATCH.
module tb_game_setup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_confirm, game_over, setup_ack;
  logic [1:0]  level;
  logic        in_menu, latch_en, set_valid, playing;
  logic [4:0]  button_num;
  logic [6:0]  button_size;
  logic [9:0]  board_size;
  logic [10:0] board_xpos, board_ypos;

  int checks = 0;
  int errors = 0;

  game_setup_ctrl #(.SCREEN_W(1024), .SCREEN_H(768)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_confirm(btn_confirm),
    .game_over(game_over), .setup_ack(setup_ack),
    .level(level), .in_menu(in_menu), .latch_en(latch_en),
    .set_valid(set_valid), .playing(playing),
    .button_num(button_num), .button_size(button_size), .board_size(board_size),
    .board_xpos(board_xpos), .board_ypos(board_ypos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       down;
    logic [1:0] exp_level;
  } lvl_vec_t;

  typedef struct {
    logic [1:0]  lv;
    logic        with_up;
    logic [4:0]  num;
    logic [6:0]  size;
    logic [9:0]  board;
    logic [10:0] x;
    logic [10:0] y;
  } geom_vec_t;

  lvl_vec_t  lvl_tab[8];
  geom_vec_t geom_tab[3];
  logic [1:0] cur_level;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle button pulse, then one more cycle for the registered press to take effect.
  task automatic press(input logic up, input logic down);
    btn_up = up; btn_down = down;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
    tick();
  endtask

  task automatic run_flow(input geom_vec_t g);
    btn_confirm = 1'b1; btn_up = g.with_up;
    tick();                                   // edge k: confirm sampled
    btn_confirm = 1'b0; btn_up = 1'b0;
    chk("menu_after_confirm", in_menu, 1);
    chk("latch_en_k", latch_en, 0);
    tick();                                   // k+1: COMPUTE
    chk("compute_in_menu", in_menu, 0);
    chk("latch_en_k1", latch_en, 0);
    tick();                                   // k+2: LATCH
    chk("latch_en_k2", latch_en, 1);
    chk("level_kept", level, g.lv);
    chk("button_num", button_num, g.num);
    chk("button_size", button_size, g.size);
    chk("board_size", board_size, g.board);
    chk("board_xpos", board_xpos, g.x);
    chk("board_ypos", board_ypos, g.y);
    tick();                                   // k+3: WAIT_ACK
    chk("latch_en_k3", latch_en, 0);
    chk("set_valid_k3", set_valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("wait_set_valid", set_valid, 1);
      chk("wait_playing", playing, 0);
      chk("wait_latch_en", latch_en, 0);
    end
    setup_ack = 1'b1;
    tick();
    setup_ack = 1'b0;
    chk("ack_playing", playing, 1);
    chk("ack_set_valid", set_valid, 0);
    btn_confirm = 1'b1;
    tick();
    btn_confirm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("play_confirm_ignored", playing, 1);
      chk("play_latch_en", latch_en, 0);
    end
    chk("play_board_hold", board_size, g.board);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk("over_in_menu", in_menu, 1);
    chk("over_board_hold", board_size, g.board);
    chk("over_xpos_hold", board_xpos, g.x);
    chk("over_ypos_hold", board_ypos, g.y);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk("menu_over_ignored", in_menu, 1);
    chk("menu_latch_en", latch_en, 0);
    tick();
    chk("menu_over_ignored2", in_menu, 1);
    chk("menu_level_hold", level, g.lv);
  endtask

  initial begin
    lvl_tab[0] = '{1'b1, 1'b0, 2'd1};
    lvl_tab[1] = '{1'b1, 1'b0, 2'd2};
    lvl_tab[2] = '{1'b1, 1'b0, 2'd0};
    lvl_tab[3] = '{1'b0, 1'b1, 2'd2};
    lvl_tab[4] = '{1'b1, 1'b1, 2'd2};
    lvl_tab[5] = '{1'b0, 1'b1, 2'd1};
    lvl_tab[6] = '{1'b0, 1'b1, 2'd0};
    lvl_tab[7] = '{1'b0, 1'b0, 2'd0};

    geom_tab[0] = '{2'd2, 1'b0, 5'd16, 7'd40, 10'd640, 11'd192, 11'd64};
    geom_tab[1] = '{2'd0, 1'b0, 5'd8,  7'd64, 10'd512, 11'd256, 11'd128};
    geom_tab[2] = '{2'd1, 1'b1, 5'd12, 7'd48, 10'd576, 11'd224, 11'd96};

    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_confirm = 1'b0;
    game_over = 1'b0; setup_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_in_menu", in_menu, 0);
    chk("rst_latch_en", latch_en, 0);
    chk("rst_set_valid", set_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_board", board_size, 0);
    chk("rst_xpos", board_xpos, 0);
    rst_n = 1'b1;
    chk("idle_in_menu", in_menu, 0);
    tick();
    chk("menu_after_idle", in_menu, 1);

    for (int i = 0; i < 8; i++) begin
      press(lvl_tab[i].up, lvl_tab[i].down);
      chk($sformatf("level_vec%0d", i), level, lvl_tab[i].exp_level);
      chk("level_vec_in_menu", in_menu, 1);
    end
    cur_level = 2'd0;

    for (int i = 0; i < 3; i++) begin
      while (cur_level != geom_tab[i].lv) begin
        press(1'b1, 1'b0);
        cur_level = (cur_level == 2'd2) ? 2'd0 : cur_level + 2'd1;
        chk("seek_level", level, cur_level);
      end
      run_flow(geom_tab[i]);
    end

    press(1'b1, 1'b0);
    chk("pre_reset_level", level, 2);
    btn_confirm = 1'b1;
    tick();
    btn_confirm = 1'b0;
    tick();
    tick();
    chk("pre_reset_latch_en", latch_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_latch_en", latch_en, 0);
    chk("async_level", level, 0);
    chk("async_set_valid", set_valid, 0);
    chk("async_playing", playing, 0);
    chk("async_board", board_size, 0);
    #1;
    rst_n = 1'b1;
    chk("rel_in_menu", in_menu, 0);
    tick();
    chk("rel_menu", in_menu, 1);
    chk("rel_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
